// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: FSM states, stage bit
// positions, uCode field positions and word-width formulas.
package ucode_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    // Bit index of each layer inside the one-hot Stage selector
    localparam int SB_CONV1  = 6;
    localparam int SB_MAXP   = 5;
    localparam int SB_CONV2  = 4;
    localparam int SB_CONV3  = 3;
    localparam int SB_GMAXP  = 2;
    localparam int SB_FC1    = 1;
    localparam int SB_FC2    = 0;

    // Pipeline word, LSB upward; Adder_Ctrl and Adder_Input sit above the mul field
    localparam int PL_CDONE  = 0;
    localparam int PL_ALU    = 1;
    localparam int PL_SEL    = 2;
    localparam int PL_MUXC   = 3;
    localparam int PL_MUL    = 4;

    localparam int MODE_BITS  = 9;
    localparam int WMODE_BITS = 5;

    function automatic int pipe_w(input int num_mul);
        return num_mul + 7;
    endfunction

    function automatic int data_w(input int wb, input int db);
        return wb + db + MODE_BITS + 1;
    endfunction

    function automatic int wt_w(input int hb, input int db);
        return hb + db + WMODE_BITS + 1;
    endfunction

    function automatic logic is_onehot7(input logic [6:0] s);
        return (s != 7'd0) && ((s & (s - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/ucode_sequencer_loop_counter_nest.sv
// H/W/D loop counters. H is innermost only when i_use_h is set; otherwise it
// is held at 0 and W is innermost. o_last flags the beat with every counter at max.
module loop_counter_nest #(
    parameter int HEIGHT_BITS = 4,
    parameter int WIDTH_BITS  = 9,
    parameter int DEPTH_BITS  = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_advance,
    input  logic                   i_use_h,
    input  logic [HEIGHT_BITS-1:0] i_h_max,
    input  logic [WIDTH_BITS-1:0]  i_w_max,
    input  logic [DEPTH_BITS-1:0]  i_d_max,
    output logic [HEIGHT_BITS-1:0] o_h,
    output logic [WIDTH_BITS-1:0]  o_w,
    output logic [DEPTH_BITS-1:0]  o_d,
    output logic                   o_last
);
    logic [HEIGHT_BITS-1:0] r_h;
    logic [WIDTH_BITS-1:0]  r_w;
    logic [DEPTH_BITS-1:0]  r_d;
    logic w_h_top, w_w_top, w_d_top;

    assign w_h_top = !i_use_h || (r_h == i_h_max);
    assign w_w_top = (r_w == i_w_max);
    assign w_d_top = (r_d == i_d_max);
    assign o_last  = w_h_top && w_w_top && w_d_top;
    assign o_h = r_h;
    assign o_w = r_w;
    assign o_d = r_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h <= '0;
            r_w <= '0;
            r_d <= '0;
        end else if (i_clear) begin
            r_h <= '0;
            r_w <= '0;
            r_d <= '0;
        end else if (i_advance) begin
            r_h <= w_h_top ? '0 : r_h + 1'b1;
            if (w_h_top)
                r_w <= w_w_top ? '0 : r_w + 1'b1;
            if (w_h_top && w_w_top)
                r_d <= w_d_top ? '0 : r_d + 1'b1;
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks the per-layer loop nest and emits registered
// pipeline / data-read / data-write / weight-read words, one per beat.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int                 WIDTH_BITS    = 9,
    parameter int                 DEPTH_BITS    = 5,
    parameter int                 HEIGHT_BITS   = 4,
    parameter int                 NUM_MUL       = 6,
    parameter logic [NUM_MUL-1:0] CONV_MUL_MASK = 6'b011100,
    parameter logic [NUM_MUL-1:0] FC_MUL_MASK   = 6'b011111,
    parameter int                 FC_STRIDE     = 5,
    parameter int                 DRAIN_CYCLES  = 4
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   Start,
    input  logic [6:0]                             Stage,
    input  logic [HEIGHT_BITS-1:0]                 Height_max,
    input  logic [WIDTH_BITS-1:0]                  Width_max,
    input  logic [DEPTH_BITS-1:0]                  Depth_max,
    input  logic                                   Stall,
    output logic [pipe_w(NUM_MUL)-1:0]             pipeline_uCode,
    output logic [data_w(WIDTH_BITS,DEPTH_BITS)-1:0] Data_Read_uCode,
    output logic [data_w(WIDTH_BITS,DEPTH_BITS)-1:0] Data_Write_uCode,
    output logic [wt_w(HEIGHT_BITS,DEPTH_BITS)-1:0]  Weight_Read_uCode,
    output logic                                   uCode_Valid,
    output logic                                   Busy,
    output logic                                   Done,
    output logic                                   Cfg_Error
);
    localparam int PW  = pipe_w(NUM_MUL);
    localparam int DW  = data_w(WIDTH_BITS, DEPTH_BITS);
    localparam int TW  = wt_w(HEIGHT_BITS, DEPTH_BITS);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    seq_state_t r_state, w_state_nxt;
    logic [6:0]             r_stage;
    logic [HEIGHT_BITS-1:0] r_hmax, w_h;
    logic [WIDTH_BITS-1:0]  r_wmax, w_w;
    logic [DEPTH_BITS-1:0]  r_dmax, w_d;
    logic [DCW-1:0]         r_drain_cnt;
    logic r_busy, r_done, r_cfg_err, r_valid;
    logic [PW-1:0] r_pipe, w_pipe;
    logic [DW-1:0] r_rd, r_wr, w_rd, w_wr;
    logic [TW-1:0] r_wt, w_wt;
    logic w_accept, w_cfg_err, w_drain_end, w_advance, w_last, w_pool;

    logic [NUM_MUL-1:0]     w_mul, w_msb;
    logic [1:0]             w_ctrl;
    logic                   w_ai, w_mux, w_cd, w_wr_en;
    logic [WIDTH_BITS-1:0]  w_rd_w, w_wr_w;
    logic [DEPTH_BITS-1:0]  w_rd_d, w_wr_d, w_wt_d;
    logic [HEIGHT_BITS-1:0] w_wt_w;

    assign w_advance = (r_state == S_RUN) && !Stall;

    loop_counter_nest #(
        .HEIGHT_BITS(HEIGHT_BITS), .WIDTH_BITS(WIDTH_BITS), .DEPTH_BITS(DEPTH_BITS)
    ) u_loops (
        .i_clk(Clk), .i_rst(Reset), .i_clear(w_accept), .i_advance(w_advance),
        .i_use_h(r_stage[SB_CONV2] | r_stage[SB_CONV3]),
        .i_h_max(r_hmax), .i_w_max(r_wmax), .i_d_max(r_dmax),
        .o_h(w_h), .o_w(w_w), .o_d(w_d), .o_last(w_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cfg_err   = 1'b0;
        w_drain_end = 1'b0;
        case (r_state)
            S_IDLE: if (Start) begin
                if (is_onehot7(Stage)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cfg_err = 1'b1;
                end
            end
            S_RUN: if (!Stall && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!Stall && r_drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
                w_drain_end = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word encoding for the beat at the current counter values
    always_comb begin
        w_msb = '0;
        w_msb[NUM_MUL-1] = 1'b1;
        w_mul = '0; w_ctrl = 2'b00; w_ai = 1'b0; w_mux = 1'b0; w_cd = 1'b0; w_wr_en = 1'b1;
        w_rd_w = '0; w_rd_d = '0; w_wr_w = '0; w_wr_d = '0; w_wt_w = '0; w_wt_d = '0;
        if (r_stage[SB_CONV1]) begin
            w_ctrl = 2'b11; w_mul = '1; w_wt_d = w_d;
            w_rd_w = w_w; w_wr_w = w_w; w_wr_d = w_d;
        end else if (r_stage[SB_MAXP]) begin
            w_mux = 1'b1; w_rd_w = {w_w[WIDTH_BITS-2:0], 1'b0}; w_rd_d = w_d;
            w_wr_w = w_w; w_wr_d = w_d;
        end else if (r_stage[SB_CONV2] || r_stage[SB_CONV3]) begin
            w_ai   = (w_h != '0);
            w_ctrl = {2{w_h == r_hmax}};
            w_mul  = CONV_MUL_MASK | ((w_h == '0) ? w_msb : '0);
            w_wt_w = w_h; w_wt_d = w_d;
            w_rd_w = w_w; w_rd_d = DEPTH_BITS'(w_h);
            w_wr_w = w_w; w_wr_d = w_d;
        end else if (r_stage[SB_GMAXP]) begin
            w_mux = 1'b1; w_rd_w = w_w; w_rd_d = w_d; w_wr_w = WIDTH_BITS'(w_d);
        end else if (r_stage[SB_FC1] || r_stage[SB_FC2]) begin
            w_ai   = (w_w != '0);
            w_ctrl = {2{w_w == r_wmax}};
            w_mul  = FC_MUL_MASK | ((w_w == '0) ? w_msb : '0);
            w_wt_w = w_w[HEIGHT_BITS-1:0];
            w_wr_w = WIDTH_BITS'(w_d);
            if (r_stage[SB_FC1]) begin
                w_wt_d = w_d;
                w_rd_w = WIDTH_BITS'(w_w * FC_STRIDE);
            end else begin
                w_wr_en = 1'b0;
                w_cd    = w_last;
            end
        end
    end

    always_comb begin
        w_pipe = '0;
        w_pipe[PL_CDONE] = w_cd;
        w_pipe[PL_ALU]   = w_mux;
        w_pipe[PL_SEL]   = w_mux;
        w_pipe[PL_MUXC]  = w_mux;
        w_pipe[PL_MUL +: NUM_MUL]       = w_mul;
        w_pipe[PL_MUL + NUM_MUL +: 2]   = w_ctrl;
        w_pipe[PL_MUL + NUM_MUL + 2]    = w_ai;
    end

    assign w_pool = r_stage[SB_MAXP] | r_stage[SB_GMAXP];
    assign w_rd = {w_rd_w, w_rd_d, 2'b00, r_stage, 1'b1};
    assign w_wr = {w_wr_w, w_wr_d, 2'b00, r_stage, w_wr_en};
    assign w_wt = w_pool ? '0 : {w_wt_w, w_wt_d, r_stage[WMODE_BITS-1:0], 1'b1};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stage <= '0; r_hmax <= '0; r_wmax <= '0; r_dmax <= '0;
            r_drain_cnt <= '0; r_busy <= 1'b0; r_done <= 1'b0; r_cfg_err <= 1'b0;
            r_pipe <= '0; r_rd <= '0; r_wr <= '0; r_wt <= '0; r_valid <= 1'b0;
        end else begin
            r_done    <= w_drain_end;
            r_cfg_err <= w_cfg_err;
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_stage <= Stage;
                r_hmax  <= Height_max;
                r_wmax  <= Width_max;
                r_dmax  <= Depth_max;
            end else if (w_drain_end) begin
                r_busy <= 1'b0;
            end
            if (r_state != S_DRAIN) r_drain_cnt <= '0;
            else if (!Stall)        r_drain_cnt <= r_drain_cnt + 1'b1;
            // Stall freezes the words in flight; IDLE is already all-zero
            if (!(Stall && r_state != S_IDLE)) begin
                r_valid <= w_advance;
                r_pipe  <= w_advance ? w_pipe : '0;
                r_rd    <= w_advance ? w_rd   : '0;
                r_wr    <= w_advance ? w_wr   : '0;
                r_wt    <= w_advance ? w_wt   : '0;
            end
        end
    end

    assign pipeline_uCode    = r_pipe;
    assign Data_Read_uCode   = r_rd;
    assign Data_Write_uCode  = r_wr;
    assign Weight_Read_uCode = r_wt;
    assign uCode_Valid       = r_valid;
    assign Busy              = r_busy;
    assign Done              = r_done;
    assign Cfg_Error         = r_cfg_err;

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Parametrised microcode sequencer for the ECG CNN accelerator. Given a one-hot layer selector and per-layer loop bounds, it generates the Height/Width/Depth loop nest itself and emits one registered set of pipeline, data-read, data-write and weight-read microcode words per beat. It sits between the layer controller and the datapath/memory address generators. It adds start/busy/done handshake, stall support, a drain phase and configurable accumulate boundaries in place of fixed constants.

## Interface
- WIDTH_BITS, 9, width counter/field width
- DEPTH_BITS, 5, depth counter/field width
- HEIGHT_BITS, 4, height counter/field width
- NUM_MUL, 6, multiplier paths
- CONV_MUL_MASK, 6'b011100, mul enables for conv beats with H!=0
- FC_MUL_MASK, 6'b011111, mul enables for FC beats with W!=0
- FC_STRIDE, 5, FC data-read width multiplier
- DRAIN_CYCLES, 4, datapath latency waited before Done
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- Start  in  1  one-cycle request; sampled only in IDLE
- Stage  in  7  one-hot layer: [6] CONV1D_1st, [5] MaxPool, [4] CONV1D_2nd, [3] CONV1D_3rd, [2] Global_MaxPool, [1] FC_1st, [0] FC_2nd
- Height_max / Width_max / Depth_max  in  HEIGHT_BITS / WIDTH_BITS / DEPTH_BITS  inclusive loop bounds, latched at Start
- Stall  in  1  freezes counters and outputs
- pipeline_uCode  out  NUM_MUL+7  {Adder_Input, Adder_Ctrl[1:0], Mul_Path_Enable, Mul_Mux_Control, Mul_Mux_Sel, ALU_Mux, Compute_Done}
- Data_Read_uCode, Data_Write_uCode  out  WIDTH_BITS+DEPTH_BITS+10  {Width, Depth, Mode[8:0], Enable}
- Weight_Read_uCode  out  HEIGHT_BITS+DEPTH_BITS+6  {Width[HEIGHT_BITS-1:0], Depth, Mode[4:0], Enable}
- uCode_Valid  out  1  words valid this cycle
- Busy  out  1  high from accepted Start until Done
- Done  out  1  one-cycle pulse at end of drain
- Cfg_Error  out  1  one-cycle pulse: Start with non-one-hot Stage

## Operation
- FSM: IDLE -> RUN -> DRAIN -> IDLE. Start in IDLE with a one-hot Stage latches Stage and bounds and enters RUN with counters H=W=D=0. Start with non-one-hot Stage pulses Cfg_Error and stays IDLE. Start outside IDLE is ignored.
- Loop order (inner first): CONV1D_2nd/3rd use H, W, D. All other stages use W, D; H is held 0.
- RUN emits one beat per unstalled cycle. After the beat with all counters at their max, the FSM enters DRAIN for DRAIN_CYCLES cycles, pulses Done, and returns to IDLE.
- Mode field = 9-bit one-hot {2'b00, Stage}. Weight Mode = Stage[4:0] for CONV2/CONV3/FC stages, 0 otherwise.
- Per-stage words (fields not listed are 0):
  - CONV1D_1st: Adder_Ctrl=11, all mul paths enabled. Weight {0, D, Enable}. Read {W, 0}. Write {W, D}.
  - MaxPool: Mul_Mux_Control/Sel and ALU_Mux=1. Weight word all zero. Read {(W<<1) truncated to WIDTH_BITS, D}. Write {W, D}.
  - CONV1D_2nd/3rd: Adder_Input=(H!=0). Adder_Ctrl=11 iff H==Height_max. Mul enables = CONV_MUL_MASK with MSB forced 1 when H==0. Weight {H, D}. Read {W, zero-extended H}. Write {W, D}.
  - Global_MaxPool: as MaxPool, but Read {W, D} and Write {zero-extended D, 0}.
  - FC_1st: Adder_Input=(W!=0). Adder_Ctrl=11 iff W==Width_max. Mul enables = FC_MUL_MASK with MSB forced 1 when W==0. Weight {W[HEIGHT_BITS-1:0], D}. Read {W*FC_STRIDE truncated, 0}. Write {zero-extended D, 0}.
  - FC_2nd: as FC_1st, but weight Depth=0, Read {0, 0}, Write Enable=0, and Compute_Done=1 on the final beat.
- Enable bits are 1 on every RUN beat, except Write Enable in FC_2nd and the Weight word in the pooling stages.

## Timing
- Outputs are registered. The first beat appears the cycle after Start is accepted; uCode_Valid is aligned with the words.
- Stall=1 holds counters, all uCode outputs and uCode_Valid; a stall during DRAIN also holds the drain counter. Stall in IDLE has no effect.
- In IDLE and DRAIN, all uCode outputs and uCode_Valid are 0.
- Reset (any time, including mid-RUN): FSM to IDLE; all outputs, counters and latched config to 0 within the same cycle.
- Bounds of 0 give a single beat. Counters never exceed their latched max and wrap to 0 when the next-outer counter advances.
- Busy falls in the same cycle Done pulses. Start is accepted again on the following cycle.

## Structure
- Shared package `ucode_pkg`: stage one-hot localparams, uCode field bit-position localparams, and the width formulas for the uCode words.
- Sub-module `loop_counter_nest`: H/W/D counters with stall, per-stage loop-order select and a last-beat flag. The FSM and word encoding stay in the top module.

## Test plan
- CONV1D_2nd, Height_max=7, Width_max=2, Depth_max=1, no stall → 48 beats. Adder_Ctrl=11 exactly on H=7 beats. Mul enables 111100 on H=0, 011100 otherwise. Done pulses 4 cycles after the last beat.
- MaxPool, Width_max=3, Depth_max=0 → Read Width sequence 0,2,4,6; Write Width sequence 0,1,2,3; Weight word 0 throughout.
- FC_2nd, Width_max=4, Depth_max=0 → 5 beats. Compute_Done=1 only on W=4. Write Enable stays 0.
- Stall high for 3 cycles mid-CONV1D_1st → outputs frozen for 3 cycles, no beat lost or duplicated, total beat count unchanged.
- Reset asserted at beat 10 of a FC_1st run → all outputs 0 immediately and Busy=0. A new Start with CONV1D_3rd then runs normally from H=W=D=0.
- Start with Stage=7'b0000011 → Cfg_Error pulses, Busy stays 0, no beats. Start during RUN → ignored.
